i2s_xmit: RTL
=============

# i2s_xmit

I2S transmitter for the pedal audio path. It sits downstream of the effect stage, in the same role on the output side that the I2S receiver plays on the input side. It accepts parallel 24-bit left/right sample pairs through a valid/ready handshake. It generates the bit clock (bck) and frame clock (lrck) from the master clock, and serializes each pair MSB-first in standard I2S format (data delayed one bck after each lrck edge). A one-entry holding register decouples the producer from frame timing; a missing sample pair produces a silent frame and an underrun pulse.

## Interface
- WIDTH, 24, sample width in bits per channel
- MCK_PER_BCK, 4, mck cycles per bck period; even, ≥2
- SLOT_BITS, 32, bck periods per channel slot; ≥ WIDTH+1
- mck  input  1  master clock; all logic on posedge
- rst  input  1  asynchronous, active-high reset
- in_left  input  WIDTH  left sample, two's complement
- in_right  input  WIDTH  right sample
- in_valid  input  1  sample pair presented
- in_ready  output  1  holding register empty; pair accepted when in_valid && in_ready
- bck  output  1  I2S bit clock
- lrck  output  1  I2S frame clock; 0 = left, 1 = right
- sdata  output  1  I2S serial data; changes on bck falling edge
- frame_start  output  1  one-mck pulse when a new frame begins
- underrun  output  1  one-mck pulse when a frame begins with no pair held

## Operation
- div_cnt counts 0..MCK_PER_BCK-1 and wraps. bit_cnt counts 0..2*SLOT_BITS-1 and wraps. hold_full flags the holding register. frame_l and frame_r hold the frame being shifted.
- Half edge: on the mck edge where div_cnt goes MCK_PER_BCK/2-1 → MCK_PER_BCK/2, bck goes to 1. Nothing else changes on this edge.
- Bit tick: on the mck edge where div_cnt goes MCK_PER_BCK-1 → 0, bck goes to 0 and bit_cnt advances to b. Let q = b mod SLOT_BITS:
  - lrck ← (b ≥ SLOT_BITS).
  - sdata ← channel sample bit [WIDTH-q] when 1 ≤ q ≤ WIDTH, else 0. The channel is frame_l when b < SLOT_BITS, frame_r otherwise.
- Frame boundary is the bit tick where bit_cnt wraps 2*SLOT_BITS-1 → 0. On that edge:
  - frame_start pulses.
  - If hold_full: frame regs ← holding regs and hold_full ← 0.
  - Else: frame regs ← 0 and underrun pulses.
- Accept: when in_valid && in_ready, the holding regs load and hold_full ← 1. in_ready = !hold_full, so an accept and a frame-boundary load never coincide on a full register.
- An accept on the same edge as a frame boundary with an empty register counts as an underrun for the current frame. The accepted pair plays in the next frame.
- All outputs are flops or derived directly from flops (in_ready = !hold_full). No combinational path from inputs to outputs.

## Timing
- Reset values: bck=0, lrck=0, sdata=0, in_ready=1, frame_start=0, underrun=0, div_cnt=0, bit_cnt=0, hold_full=0, frame regs=0.
- The first frame after reset is silent. No frame_start or underrun is asserted for it.
- bck period = MCK_PER_BCK mck cycles at 50% duty; the first rising edge comes MCK_PER_BCK/2 edges after reset release.
- Frame = 2*SLOT_BITS bck = 2*SLOT_BITS*MCK_PER_BCK mck cycles; 256 with defaults.
- Left MSB appears on sdata at bit_cnt=1, one bck after lrck falls. Right MSB appears at bit_cnt=SLOT_BITS+1. Each bit is stable across the following bck rising edge.
- Latency: a pair accepted at any time during frame N plays in frame N+1, as long as the register was empty.
- Handshake: a producer that holds in_valid may see in_ready low for up to one frame. in_ready rises one mck after the frame-boundary edge that consumes the held pair.
- Reset asserted mid-frame clears everything immediately, including a held pair. Counting restarts from the reset state, with no partial-frame completion.

## Test plan
- Reset: hold rst 5 mck, release → all outputs at reset values. First bck rise at edge 2 and first fall at edge 4 (defaults). lrck first rises 128 mck after release.
- Single frame: accept left=0x888888, right=0x123456 during frame 0. Sample sdata on bck rising in frame 1 → left bits 1..24 = 100010001000100010001000, bits 25..31 = 0. Right reads 0x123456 with lrck=1. frame_start pulses once at frame start.
- Backpressure: hold in_valid with pairs A then B. A accepted immediately, in_ready low. B accepted 1 mck after the frame boundary that loads A. A plays in frame 1, B in frame 2.
- Underrun: no input for 3 frames → sdata constantly 0. underrun pulses exactly once per frame, coincident with frame_start.
- Mid-frame reset: assert rst at bit_cnt=10 of a loaded frame → outputs at reset values immediately, held pair lost. After release, timing is identical to the first scenario.
- Extremes: left=0x7FFFFF, right=0x800000 → left MSB 0 followed by 23 ones; right MSB 1 followed by 23 zeros.

Source files
------------

// File: rtl/i2s_xmit_if.sv
// Sample-pair handshake between an audio producer and the I2S transmitter.
// The producer presents a left/right pair with in_valid; the transmitter
// raises in_ready while its holding register is empty.
interface i2s_xmit_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_left,
    output in_right,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_left,
    input  in_right,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/i2s_xmit.sv
// I2S transmitter: derives bck/lrck from mck and shifts out left/right
// samples MSB-first, one bck after each lrck edge. A single holding
// register decouples the producer from frame timing; a frame that starts
// with nothing held is sent as silence and flagged with an underrun pulse.
module i2s_xmit #(
  parameter int WIDTH       = 24,
  parameter int MCK_PER_BCK = 4,
  parameter int SLOT_BITS   = 32
) (
  input  logic         mck,
  input  logic         rst,
  i2s_xmit_if.slave    in_bus,
  output logic         bck,
  output logic         lrck,
  output logic         sdata,
  output logic         frame_start,
  output logic         underrun
);

  localparam int DCW = $clog2(MCK_PER_BCK);
  localparam int BCW = $clog2(2 * SLOT_BITS);

  localparam logic [DCW-1:0] DIV_LAST = DCW'(MCK_PER_BCK - 1);
  localparam logic [DCW-1:0] DIV_HALF = DCW'(MCK_PER_BCK / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(2 * SLOT_BITS - 1);
  localparam logic [BCW-1:0] SLOT_C   = BCW'(SLOT_BITS);
  localparam logic [BCW-1:0] WIDTH_C  = BCW'(WIDTH);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);

  logic [DCW-1:0]   div_cnt_r;
  logic [BCW-1:0]   bit_cnt_r;
  logic             hold_full_r;
  logic [WIDTH-1:0] hold_left_r;
  logic [WIDTH-1:0] hold_right_r;
  logic [WIDTH-1:0] frame_left_r;
  logic [WIDTH-1:0] frame_right_r;

  logic             tick_s;
  logic             half_s;
  logic             wrap_s;
  logic             accept_s;
  logic [BCW-1:0]   bit_next_s;
  logic             right_half_s;
  logic [BCW-1:0]   q_s;
  logic [BCW-1:0]   idx_s;
  logic [WIDTH-1:0] chan_s;
  logic [WIDTH-1:0] shifted_s;
  logic             sdata_next_s;

  // in_ready is the inverse of the holding-register flag, never a function of inputs
  assign in_bus.in_ready = !hold_full_r;

  // Next bit position, slot selection and the serial bit that goes with it
  always_comb begin
    tick_s       = (div_cnt_r == DIV_LAST);
    half_s       = (div_cnt_r == DIV_HALF);
    wrap_s       = tick_s && (bit_cnt_r == BIT_LAST);
    accept_s     = in_bus.in_valid && !hold_full_r;
    bit_next_s   = {BCW{1'b0}};
    q_s          = {BCW{1'b0}};
    chan_s       = {WIDTH{1'b0}};
    sdata_next_s = 1'b0;
    if (bit_cnt_r == BIT_LAST) begin
      bit_next_s = {BCW{1'b0}};
    end else begin
      bit_next_s = bit_cnt_r + BIT_ONE;
    end
    right_half_s = (bit_next_s >= SLOT_C);
    if (right_half_s) begin
      q_s    = bit_next_s - SLOT_C;
      chan_s = frame_right_r;
    end else begin
      q_s    = bit_next_s;
      chan_s = frame_left_r;
    end
    // Slot position q carries sample bit WIDTH-q; positions 0 and >WIDTH are padding
    idx_s     = WIDTH_C - q_s;
    shifted_s = chan_s >> idx_s;
    if ((q_s != {BCW{1'b0}}) && (q_s <= WIDTH_C)) begin
      sdata_next_s = shifted_s[0];
    end else begin
      sdata_next_s = 1'b0;
    end
  end

  // Bit-clock divider, bit counter and the registered I2S pins and pulses
  always_ff @(posedge mck or posedge rst) begin
    if (rst) begin
      div_cnt_r   <= {DCW{1'b0}};
      bit_cnt_r   <= {BCW{1'b0}};
      bck         <= 1'b0;
      lrck        <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (tick_s) begin
        div_cnt_r <= {DCW{1'b0}};
        bck       <= 1'b0;
        bit_cnt_r <= bit_next_s;
        lrck      <= right_half_s;
        sdata     <= sdata_next_s;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_ONE;
        if (half_s) begin
          bck <= 1'b1;
        end
      end
      frame_start <= wrap_s;
      underrun    <= wrap_s && !hold_full_r;
    end
  end

  // Holding register fill and hand-over to the frame registers at each frame boundary
  always_ff @(posedge mck or posedge rst) begin
    if (rst) begin
      hold_full_r   <= 1'b0;
      hold_left_r   <= {WIDTH{1'b0}};
      hold_right_r  <= {WIDTH{1'b0}};
      frame_left_r  <= {WIDTH{1'b0}};
      frame_right_r <= {WIDTH{1'b0}};
    end else begin
      if (wrap_s) begin
        if (hold_full_r) begin
          frame_left_r  <= hold_left_r;
          frame_right_r <= hold_right_r;
        end else begin
          frame_left_r  <= {WIDTH{1'b0}};
          frame_right_r <= {WIDTH{1'b0}};
        end
      end
      // accept_s implies an empty register, so it never races the boundary unload;
      // a pair accepted on a boundary with nothing held waits for the next frame
      if (accept_s) begin
        hold_left_r  <= in_bus.in_left;
        hold_right_r <= in_bus.in_right;
        hold_full_r  <= 1'b1;
      end else if (wrap_s) begin
        hold_full_r <= 1'b0;
      end
    end
  end

endmodule
